// File: rtl/trojan0_multichannel_counter_host.sv
// Multi-channel counter/timer host: NUM_CH channels (up/down/periodic/one-shot) plus a key generator
// feeding Trojan0; each channel's registered value is XOR-mixed with a rotated slice of load.

module trojan0 #(
    parameter logic [63:0] LOAD_VALUE = 64'h0,
    parameter logic [63:0] KEY_MASK   = 64'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    output logic [63:0]  load
);
    // Stand-in payload: constant load, optionally folded with masked key halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) load <= '0;
        else     load <= LOAD_VALUE ^ ((key[127:64] ^ key[63:0]) & KEY_MASK);
    end
endmodule

module trojan0_multichannel_counter_host #(
    parameter int           NUM_CH          = 4,
    parameter int           COUNT_WIDTH     = 16,
    parameter int           DEFAULT_PERIOD  = 100,
    parameter logic [127:0] KEY_INIT        = 128'h13579BDF02468ACE13579BDF02468ACE,
    parameter logic [63:0]  TROJAN_LOAD     = 64'h0,
    parameter logic [63:0]  TROJAN_KEY_MASK = 64'h0,
    localparam int          CHW             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH-1:0]             ch_enable,
    input  logic [2*NUM_CH-1:0]           mode,
    input  logic [NUM_CH-1:0]             ch_start,
    input  logic [NUM_CH-1:0]             ch_clear,
    input  logic                          cfg_we,
    input  logic [CHW-1:0]                cfg_ch,
    input  logic [COUNT_WIDTH-1:0]        cfg_period,
    output logic [NUM_CH*COUNT_WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]             overflow,
    output logic [NUM_CH-1:0]             pulse_out,
    output logic [NUM_CH-1:0]             done,
    output logic                          busy
);
    typedef enum logic [1:0] {OS_IDLE, OS_RUN, OS_DONE} os_state_e;

    logic [COUNT_WIDTH-1:0] cnt_q    [NUM_CH];
    logic [COUNT_WIDTH-1:0] cnt_d    [NUM_CH];
    logic [COUNT_WIDTH-1:0] period_q [NUM_CH];
    logic [COUNT_WIDTH-1:0] period_d [NUM_CH];
    logic [COUNT_WIDTH-1:0] cout_q   [NUM_CH];
    logic [COUNT_WIDTH-1:0] mask     [NUM_CH];
    os_state_e              st_q     [NUM_CH];
    os_state_e              st_d     [NUM_CH];
    logic [NUM_CH-1:0]      ovf_q, ovf_d, pls_q, pls_d;
    logic [NUM_CH-1:0]      tick, last, is_run;
    logic [127:0]           key_q, key_d;
    logic [CHW-1:0]         ptr_q, ptr_d;
    logic [63:0]            load;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [COUNT_WIDTH-1:0] lim;
        // A zero period behaves as a period of one.
        assign lim       = (period_q[g] == '0) ? '0 : period_q[g] - 1'b1;
        assign tick[g]   = enable & ch_enable[g];
        assign last[g]   = cnt_q[g] >= lim;
        assign mask[g]   = COUNT_WIDTH'({load, load} >> ((16 * g) % 64));
        assign done[g]   = (st_q[g] == OS_DONE);
        assign is_run[g] = (st_q[g] == OS_RUN);
        assign count_out[g*COUNT_WIDTH +: COUNT_WIDTH] = cout_q[g];
    end

    assign busy      = |is_run;
    assign overflow  = ovf_q;
    assign pulse_out = pls_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            st_d[i]     = (mode[2*i +: 2] == 2'b11) ? st_q[i] : OS_IDLE;
            ovf_d[i]    = 1'b0;
            pls_d[i]    = 1'b0;
            if (cfg_we && (int'(cfg_ch) == i)) period_d[i] = cfg_period;
            if (ch_clear[i]) begin
                cnt_d[i] = '0;
                st_d[i]  = OS_IDLE;
            end else begin
                unique case (mode[2*i +: 2])
                    2'b00: if (tick[i]) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                        ovf_d[i] = &cnt_q[i];
                    end
                    2'b01: if (tick[i]) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        ovf_d[i] = (cnt_q[i] == '0);
                    end
                    2'b10: if (tick[i]) begin
                        cnt_d[i] = last[i] ? '0 : cnt_q[i] + 1'b1;
                        pls_d[i] = last[i];
                    end
                    default: begin
                        if (ch_start[i]) begin
                            cnt_d[i] = '0;
                            st_d[i]  = OS_RUN;
                        end else if (st_q[i] == OS_RUN && tick[i]) begin
                            if (last[i]) begin
                                st_d[i]  = OS_DONE;
                                pls_d[i] = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        key_d = key_q;
        ptr_d = ptr_q;
        if (enable) begin
            key_d = {key_q[119:0], key_q[127:120] ^ cnt_q[ptr_q][7:0]};
            ptr_d = (int'(ptr_q) == NUM_CH - 1) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= '0;
                period_q[i] <= COUNT_WIDTH'(DEFAULT_PERIOD);
                st_q[i]     <= OS_IDLE;
                cout_q[i]   <= '0;
            end
            ovf_q <= '0;
            pls_q <= '0;
            key_q <= KEY_INIT;
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
                st_q[i]     <= st_d[i];
                cout_q[i]   <= cnt_q[i] ^ mask[i];
            end
            ovf_q <= ovf_d;
            pls_q <= pls_d;
            key_q <= key_d;
            ptr_q <= ptr_d;
        end
    end

    trojan0 #(
        .LOAD_VALUE (TROJAN_LOAD),
        .KEY_MASK   (TROJAN_KEY_MASK)
    ) u_trojan0 (
        .clk  (clk),
        .rst  (~rst),
        .key  (key_q),
        .load (load)
    );
endmodule

// File: tb/tb_trojan0_multichannel_counter_host.sv
// Scoreboarded bench: two instances (zero-load and constant/key-folded load) driven identically
// against a behavioural model; a monitor pops one expectation per clock and compares.
module tb_trojan0_multichannel_counter_host;
    localparam int           N   = 4;
    localparam int           W   = 16;
    localparam logic [127:0] KI  = 128'h13579BDF02468ACE13579BDF02468ACE;
    localparam logic [63:0]  L1  = 64'h00000000000000FF;
    localparam logic [63:0]  M1  = 64'h00000000FFFF0000;

    logic           clk = 1'b0, rst = 1'b0, enable = 1'b0, cfg_we = 1'b0;
    logic [N-1:0]   ch_enable = '0, ch_start = '0, ch_clear = '0;
    logic [2*N-1:0] mode = '0;
    logic [1:0]     cfg_ch = '0;
    logic [W-1:0]   cfg_period = '0;
    logic [N*W-1:0] cout0, cout1;
    logic [N-1:0]   ovf0, pls0, dn0, ovf1, pls1, dn1;
    logic           busy0, busy1;

    always #5 clk = ~clk;

    trojan0_multichannel_counter_host u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable), .mode(mode),
        .ch_start(ch_start), .ch_clear(ch_clear), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .count_out(cout0), .overflow(ovf0), .pulse_out(pls0),
        .done(dn0), .busy(busy0));

    trojan0_multichannel_counter_host #(.TROJAN_LOAD(L1), .TROJAN_KEY_MASK(M1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .ch_enable(ch_enable), .mode(mode),
        .ch_start(ch_start), .ch_clear(ch_clear), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .count_out(cout1), .overflow(ovf1), .pulse_out(pls1),
        .done(dn1), .busy(busy1));

    typedef struct packed {
        logic [63:0] c0;
        logic [63:0] c1;
        logic [3:0]  ovf;
        logic [3:0]  pls;
        logic [3:0]  dn;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int checks = 0, passes = 0;

    // Reference state: counters, periods, one-shot state (0 idle, 1 run, 2 done), key, pointer, load.
    int           m_cnt[N], m_per[N], m_st[N], m_ptr;
    logic [127:0] m_key;
    logic [63:0]  m_load1;
    logic [7:0]   cur_mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] mask_of(input logic [63:0] ld, input int i);
        logic [127:0] dbl;
        dbl = {ld, ld} >> ((16 * i) % 64);
        return dbl[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_per[i] = 100; m_st[i] = 0;
        end
        m_key = KI; m_ptr = 0; m_load1 = '0;
    endtask

    // Applies the currently driven inputs to the model for the coming edge and queues the result.
    task automatic step();
        exp_t e;
        int   nc, ns, md, pe;
        logic tk;
        e = '0;
        if (!rst) begin
            model_reset();
            q.push_back(e);
            return;
        end
        for (int i = 0; i < N; i++) begin
            e.c0[16*i +: 16] = 16'(m_cnt[i]);
            e.c1[16*i +: 16] = 16'(m_cnt[i]) ^ mask_of(m_load1, i);
        end
        m_load1 = L1 ^ ((m_key[127:64] ^ m_key[63:0]) & M1);
        if (enable) begin
            m_key = (m_key << 8) | 128'((m_key >> 120) ^ 128'(m_cnt[m_ptr] % 256));
            m_ptr = (m_ptr + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            md = int'(mode[2*i +: 2]);
            tk = enable && ch_enable[i];
            pe = (m_per[i] == 0) ? 1 : m_per[i];
            nc = m_cnt[i];
            ns = (md == 3) ? m_st[i] : 0;
            if (ch_clear[i]) begin
                nc = 0; ns = 0;
            end else if (md == 0 && tk) begin
                e.ovf[i] = (m_cnt[i] == 65535);
                nc = (m_cnt[i] + 1) % 65536;
            end else if (md == 1 && tk) begin
                e.ovf[i] = (m_cnt[i] == 0);
                nc = (m_cnt[i] == 0) ? 65535 : m_cnt[i] - 1;
            end else if (md == 2 && tk) begin
                e.pls[i] = (m_cnt[i] >= pe - 1);
                nc = e.pls[i] ? 0 : m_cnt[i] + 1;
            end else if (md == 3) begin
                if (ch_start[i]) begin
                    nc = 0; ns = 1;
                end else if (m_st[i] == 1 && tk) begin
                    if (m_cnt[i] >= pe - 1) begin
                        ns = 2; e.pls[i] = 1'b1;
                    end else nc = m_cnt[i] + 1;
                end
            end
            if (cfg_we && int'(cfg_ch) == i) m_per[i] = int'(cfg_period);
            m_cnt[i] = nc;
            m_st[i]  = ns;
            e.dn[i]  = (ns == 2);
            e.busy   = e.busy | (ns == 1);
        end
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic en, input logic [3:0] ce, input logic [7:0] md,
                         input logic [3:0] st, input logic [3:0] cl, input logic we,
                         input logic [1:0] cc, input logic [15:0] cp);
        @(negedge clk);
        rst = r; enable = en; ch_enable = ce; mode = md; ch_start = st; ch_clear = cl;
        cfg_we = we; cfg_ch = cc; cfg_period = cp;
        step();
    endtask

    task automatic rnd_cycle(input int k, input logic r);
        logic [3:0] st, cl;
        logic       en;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 29) == 0) cur_mode[2*i +: 2] = 2'($urandom_range(0, 3));
            st[i] = ($urandom_range(0, 24) == 0);
            cl[i] = ($urandom_range(0, 39) == 0);
        end
        en = ((k % 60) < 4) ? 1'b0 : ($urandom_range(0, 9) < 8);
        drive(r, en, 4'($urandom | $urandom), cur_mode, st, cl, ($urandom_range(0, 9) == 0),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 19) == 0) ? 16'($urandom) : 16'($urandom_range(0, 10)));
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_cout0", 64'(cout0), 64'h0);
        check("async_cout1", 64'(cout1), 64'h0);
        check("async_ovf", 64'(ovf0 | ovf1), 64'h0);
        check("async_pulse", 64'(pls0 | pls1), 64'h0);
        check("async_done", 64'(dn0 | dn1), 64'h0);
        check("async_busy", 64'(busy0 | busy1), 64'h0);
        step();
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("count_out0", 64'(cout0), e.c0);
                check("count_out1", 64'(cout1), e.c1);
                check("overflow0", 64'(ovf0), 64'(e.ovf));
                check("overflow1", 64'(ovf1), 64'(e.ovf));
                check("pulse_out0", 64'(pls0), 64'(e.pls));
                check("pulse_out1", 64'(pls1), 64'(e.pls));
                check("done0", 64'(dn0), 64'(e.dn));
                check("busy0", 64'(busy0), 64'(e.busy));
                check("busy1", 64'(busy1), 64'(e.busy));
            end
        end
    end

    initial begin
        model_reset();
        cur_mode = '0;
        // Reset held while inputs toggle.
        for (int k = 0; k < 4; k++) rnd_cycle(k + 10, 1'b0);
        // All channels periodic with default period: pulse on the 100th tick.
        for (int k = 0; k < 105; k++) drive(1'b1, 1'b1, 4'hF, 8'hAA, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        drive(1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        // ch0 periodic p=5, ch1 down, ch2 one-shot p=3, ch3 up.
        drive(1'b1, 1'b0, 4'h0, 8'b00_11_01_10, 4'h0, 4'h0, 1'b1, 2'd0, 16'd5);
        drive(1'b1, 1'b0, 4'h0, 8'b00_11_01_10, 4'h0, 4'h0, 1'b1, 2'd2, 16'd3);
        drive(1'b1, 1'b1, 4'hF, 8'b00_11_01_10, 4'h4, 4'h0, 1'b0, 2'd0, 16'd0);
        for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 4'hF, 8'b00_11_01_10, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        drive(1'b1, 1'b1, 4'hF, 8'b00_11_01_10, 4'h4, 4'h0, 1'b0, 2'd0, 16'd0);
        drive(1'b1, 1'b1, 4'hF, 8'b00_11_01_10, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        drive(1'b1, 1'b1, 4'hF, 8'b00_11_01_10, 4'h4, 4'h4, 1'b1, 2'd2, 16'd0);
        // ch1 down to all-ones, then up-wrap back to zero; clear and cfg on the same channel.
        drive(1'b1, 1'b1, 4'h2, 8'b00_11_01_10, 4'h0, 4'h2, 1'b0, 2'd0, 16'd0);
        drive(1'b1, 1'b1, 4'h2, 8'b00_11_01_10, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        drive(1'b1, 1'b1, 4'h2, 8'b00_11_00_10, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        drive(1'b1, 1'b1, 4'h2, 8'b00_11_00_10, 4'h0, 4'h1, 1'b1, 2'd0, 16'd0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 4'hF, 8'b00_11_00_10, 4'h0, 4'h0, 1'b0, 2'd0, 16'd0);
        cur_mode = 8'b00_11_00_10;
        for (int k = 0; k < 1500; k++) rnd_cycle(k, 1'b1);
        async_reset_check();
        rnd_cycle(0, 1'b0);
        cur_mode = 8'($urandom);
        for (int k = 0; k < 1500; k++) rnd_cycle(k, 1'b1);
        @(posedge clk);
        #3;
        check("queue_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/trojan0_multichannel_counter_host.md
Name: trojan0_multichannel_counter_host

Overview:
Multi-channel programmable counter/timer host for Trojan0; parametrised successor of the single-channel counter host. It provides NUM_CH independent channels, each with a run-time period register and four counting modes (up-wrap, down-wrap, periodic, one-shot FSM). A 128-bit key generator is fed round-robin from the channel counters and drives the fixed Trojan0 interface (key[127:0] -> load[63:0]). Each channel's registered output is XOR-mixed with a rotated slice of load.

Parameters:
NUM_CH, 4, number of counter channels (1..8)
COUNT_WIDTH, 16, counter width per channel (8..64)
DEFAULT_PERIOD, 100, reset value of every period register
KEY_INIT, 128'h13579BDF02468ACE13579BDF02468ACE, key generator seed

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
enable  in  1  global count enable
ch_enable  in  NUM_CH  per-channel count enable
mode  in  2*NUM_CH  channel i mode at [2i+1:2i]: 00 up-wrap, 01 down-wrap, 10 periodic, 11 one-shot
ch_start  in  NUM_CH  one-shot start/restart strobe
ch_clear  in  NUM_CH  synchronous clear strobe
cfg_we  in  1  period write strobe
cfg_ch  in  $clog2(NUM_CH) (min 1)  period write target channel
cfg_period  in  COUNT_WIDTH  period write data
count_out  out  NUM_CH*COUNT_WIDTH  mixed counter values; channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]
overflow  out  NUM_CH  one-cycle wrap flag (modes 00/01)
pulse_out  out  NUM_CH  one-cycle period/terminal pulse (modes 10/11)
done  out  NUM_CH  one-shot complete, level
busy  out  1  OR of all channels in RUN

Behaviour:
- Reset (rst=0, async): counters, count_out, overflow, pulse_out, done = 0; periods = DEFAULT_PERIOD; one-shot FSMs = IDLE; key = KEY_INIT; round-robin pointer = 0. Trojan0 instance rst is driven by ~rst.
- A channel "ticks" on an edge where enable & ch_enable[i]=1. overflow/pulse_out are registered, asserted only on the edge that produces the wrap/terminal value, and cleared on every other edge, including non-tick edges.
- Mode 00: counter+1. All-ones -> 0 sets overflow[i].
- Mode 01: counter-1. 0 -> all-ones sets overflow[i].
- Mode 10: if counter >= period-1, counter -> 0 and pulse_out[i]=1; else +1. A period of 0 is treated as 1, so the counter stays 0 and pulses every tick.
- Mode 11 FSM, IDLE/RUN/DONE:
  - IDLE: counter holds.
  - ch_start (any state, regardless of tick) -> RUN with counter=0 and done=0.
  - RUN: counter+1 per tick. On a tick with counter >= period-1: counter holds, state -> DONE, done=1, pulse_out=1 for one cycle.
  - DONE holds until ch_start or ch_clear.
  - Leaving mode 11 forces IDLE and done=0.
  - Modes 00/10 do not use the FSM; done=0.
- ch_clear[i]: counter -> 0, FSM -> IDLE, done=0. It beats tick and ch_start in the same cycle.
- cfg_we: period[cfg_ch] <= cfg_period. Out-of-range cfg_ch is ignored. The new value is used from the next edge. Simultaneous clear and cfg write on the same channel: both take effect.
- Mode change mid-count: takes effect on the next edge; the counter value is kept (except when the FSM is forced IDLE).
- Key generator on enabled edges (global enable only):
  - key <= {key[119:0], key[127:120] ^ counter[ptr][7:0]}
  - ptr <= (ptr+1) mod NUM_CH
  - Key holds when enable=0.
- Mixing:
  - mask_i = low COUNT_WIDTH bits of load rotated right by (16*i mod 64). Widths above 64 are not allowed.
  - count_out_i <= counter_i ^ mask_i on every edge (not gated by enable). Latency: one cycle after the counter.
- Async reset mid-operation clears all state immediately; no pending strobes survive.

Test Plan:
Directed tests 1-5 use a Trojan0 stub with load = 0; test 6 uses a constant-load stub.
1. Reset: hold rst=0, toggle inputs -> all outputs 0, busy=0. Release and read back via behaviour: ch0 in mode 10 pulses after 100 ticks.
2. cfg_we ch0 period=5, mode 10, enable 12 cycles -> pulse_out[0] high on ticks 5 and 10 only; count_out[0] lags the counter by one cycle (0,1,2,3,4,0...).
3. ch1 mode 01 from reset, one tick -> counter=16'hFFFF, overflow[1]=1 for exactly one cycle, count_out[1]=16'hFFFF the next cycle.
4. ch2 mode 11 period=3:
   - ch_start -> busy=1. After 3 ticks: done[2]=1, pulse_out[2] for one cycle, counter holds 2, busy=0.
   - ch_start again -> counter 0, RUN.
   - ch_clear plus tick in the same cycle -> counter 0, IDLE.
5. enable=0 mid-run for 4 cycles -> counters and key unchanged, overflow/pulse low. Assert rst mid-run between edges -> outputs 0 immediately, without waiting for clk.
6. Stub load=64'h00000000000000FF, ch0/ch1 in mode 00 -> count_out[0] = counter0 ^ 16'h00FF, count_out[1] = counter1 (mask 0).
